// File: rtl/floating_point_square.sv
// floating_point_square: iterative x^2 for the 16-bit float format
// (sign[15], biased exponent[14:7] with bias 127, fraction[6:0] with an implicit 1).
// The mantissa product is built with a shift-add loop, one partial product per cycle.
// Zero, denormal, infinity and NaN operands bypass the loop.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | waiting for square_start; operand captured on acceptance
// SPECIAL | zero/denormal/inf/NaN operand; result written on the next edge
// CALC    | shift-add multiply, counter 0..7, one partial product per cycle
// DONE    | normalize the product, write num_o, pulse valid_o
module floating_point_square (
    input  logic        clk,
    input  logic        rst,
    input  logic        square_start,
    input  logic [15:0] num_i,
    output logic [15:0] num_o,
    output logic        valid_o,
    output logic        error_o,
    output logic        busy_o
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SPECIAL = 2'd1,
        S_CALC    = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    localparam logic [15:0] RES_ZERO = 16'h0000;
    localparam logic [15:0] RES_INF  = 16'h7F80;
    localparam logic [15:0] RES_NAN  = 16'h7FC0;

    state_t      state_q, state_d;
    logic [7:0]  exp_q;
    logic [6:0]  frac_q;
    logic [7:0]  mult_q;
    logic [15:0] acc_q;
    logic [2:0]  cnt_q;
    logic [15:0] num_q;
    logic        valid_q;
    logic        error_q;

    logic        accept;
    logic        operand_special;
    logic [7:0]  mant;
    logic [15:0] partial;
    logic        write_en;
    logic [15:0] res_num;
    logic        res_err;
    logic signed [9:0] exp_res;
    logic [6:0]  norm_frac;

    assign accept          = (state_q == S_IDLE) && square_start;
    assign operand_special = (num_i[14:7] == 8'd0) || (num_i[14:7] == 8'hFF);
    assign mant            = {1'b1, frac_q};
    assign partial         = {8'd0, mant} << cnt_q;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; starts outside IDLE are dropped
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (square_start) begin
                    state_d = operand_special ? S_SPECIAL : S_CALC;
                end
            end
            S_SPECIAL: state_d = S_IDLE;
            S_CALC: begin
                if (cnt_q == 3'd7) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode: busy flag and the result to be written this cycle
    always_comb begin
        busy_o   = (state_q != S_IDLE);
        write_en = 1'b0;
        res_num  = RES_ZERO;
        res_err  = 1'b0;
        case (state_q)
            S_SPECIAL: begin
                write_en = 1'b1;
                if (exp_q == 8'hFF) begin
                    res_num = (frac_q == 7'd0) ? RES_INF : RES_NAN;
                    res_err = 1'b1;
                end
            end
            S_DONE: begin
                write_en = 1'b1;
                if (exp_res >= 10'sd255) begin
                    res_num = RES_INF;
                    res_err = 1'b1;
                end else if (exp_res <= 10'sd0) begin
                    res_num = RES_ZERO;
                end else begin
                    res_num = {1'b0, exp_res[7:0], norm_frac};
                end
            end
            default: ;
        endcase
    end

    // Normalization: product of two 1.x mantissas lies in [1,4); bit 15 marks [2,4)
    always_comb begin
        exp_res   = $signed({1'b0, exp_q, 1'b0}) - 10'sd127 + (acc_q[15] ? 10'sd1 : 10'sd0);
        norm_frac = acc_q[15] ? acc_q[14:8] : acc_q[13:7];
    end

    // Operand capture and shift-add multiply datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_q  <= 8'd0;
            frac_q <= 7'd0;
            mult_q <= 8'd0;
            acc_q  <= 16'd0;
            cnt_q  <= 3'd0;
        end else if (accept) begin
            exp_q  <= num_i[14:7];
            frac_q <= num_i[6:0];
            mult_q <= {1'b1, num_i[6:0]};
            acc_q  <= 16'd0;
            cnt_q  <= 3'd0;
        end else if (state_q == S_CALC) begin
            if (mult_q[0]) begin
                acc_q <= acc_q + partial;
            end
            mult_q <= mult_q >> 1;
            cnt_q  <= cnt_q + 3'd1;
        end
    end

    // Result registers: num_o holds between writes, valid/error pulse for one cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            num_q   <= RES_ZERO;
            valid_q <= 1'b0;
            error_q <= 1'b0;
        end else begin
            valid_q <= write_en;
            error_q <= write_en && res_err;
            if (write_en) begin
                num_q <= res_num;
            end
        end
    end

    assign num_o   = num_q;
    assign valid_o = valid_q;
    assign error_o = error_q;

endmodule

// File: tb/tb_floating_point_square.sv
// Directed bench for floating_point_square: hand-computed vectors, latency,
// pulse width, start-ignore and mid-operation reset behaviour.
module tb_floating_point_square;

    logic        clk;
    logic        rst;
    logic        square_start;
    logic [15:0] num_i;
    logic [15:0] num_o;
    logic        valid_o;
    logic        error_o;
    logic        busy_o;

    int checks = 0;
    int errors = 0;

    floating_point_square dut (
        .clk          (clk),
        .rst          (rst),
        .square_start (square_start),
        .num_i        (num_i),
        .num_o        (num_o),
        .valid_o      (valid_o),
        .error_o      (error_o),
        .busy_o       (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // Issue one start pulse, then check the output window around the expected write edge.
    task automatic do_op(input string tag, input logic [15:0] x, input logic [15:0] exp_num,
                         input logic exp_err, input int lat);
        @(negedge clk);
        num_i        = x;
        square_start = 1'b1;
        @(negedge clk);                       // just after accepting edge k
        square_start = 1'b0;
        chk({tag, "_busy_k"}, {15'd0, busy_o}, 16'd1);
        repeat (lat - 1) @(negedge clk);      // after edge k+lat-1
        chk({tag, "_valid_pre"}, {15'd0, valid_o}, 16'd0);
        if (lat > 1) chk({tag, "_busy_pre"}, {15'd0, busy_o}, 16'd1);
        @(negedge clk);                       // after edge k+lat
        chk({tag, "_valid"}, {15'd0, valid_o}, 16'd1);
        chk({tag, "_num"}, num_o, exp_num);
        chk({tag, "_err"}, {15'd0, error_o}, {15'd0, exp_err});
        chk({tag, "_busy_done"}, {15'd0, busy_o}, 16'd0);
        @(negedge clk);                       // after edge k+lat+1
        chk({tag, "_valid_fall"}, {15'd0, valid_o}, 16'd0);
        chk({tag, "_err_fall"}, {15'd0, error_o}, 16'd0);
        chk({tag, "_num_hold"}, num_o, exp_num);
    endtask

    initial begin
        logic vseen [0:24];
        int   nvalid;

        rst          = 1'b1;
        square_start = 1'b0;
        num_i        = 16'h0000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_num", num_o, 16'h0000);
        chk("rst_valid", {15'd0, valid_o}, 16'd0);
        chk("rst_err", {15'd0, error_o}, 16'd0);
        chk("rst_busy", {15'd0, busy_o}, 16'd0);

        // Normal operands (latency 9)
        do_op("sq1p5", 16'h3FC0, 16'h4010, 1'b0, 9);
        do_op("sqm3", 16'hC040, 16'h4110, 1'b0, 9);
        do_op("trunc", 16'h3F81, 16'h3F82, 1'b0, 9);
        do_op("ovf", 16'h7180, 16'h7F80, 1'b1, 9);
        do_op("unf", 16'h0D80, 16'h0000, 1'b0, 9);
        do_op("sq2", 16'h4000, 16'h4080, 1'b0, 9);

        // Special operands (latency 1)
        do_op("negzero", 16'h8000, 16'h0000, 1'b0, 1);
        do_op("inf", 16'h7F80, 16'h7F80, 1'b1, 1);
        do_op("nan", 16'h7FC0, 16'h7FC0, 1'b1, 1);
        do_op("denorm", 16'h0005, 16'h0000, 1'b0, 1);

        // Continuous start: acceptances every 10 cycles, single-cycle valid pulses
        @(negedge clk);
        num_i        = 16'h3FC0;
        square_start = 1'b1;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            vseen[c] = valid_o;
        end
        square_start = 1'b0;
        nvalid = 0;
        for (int c = 0; c < 25; c++) if (vseen[c]) nvalid++;
        chk("cont_v8", {15'd0, vseen[8]}, 16'd0);
        chk("cont_v9", {15'd0, vseen[9]}, 16'd1);
        chk("cont_v10", {15'd0, vseen[10]}, 16'd0);
        chk("cont_v18", {15'd0, vseen[18]}, 16'd0);
        chk("cont_v19", {15'd0, vseen[19]}, 16'd1);
        chk("cont_v20", {15'd0, vseen[20]}, 16'd0);
        chk("cont_count", nvalid[15:0], 16'd2);
        chk("cont_num", num_o, 16'h4010);
        repeat (12) @(negedge clk);
        chk("cont_idle", {15'd0, busy_o}, 16'd0);

        // Operand change and stray start during CALC are ignored
        @(negedge clk);
        num_i        = 16'h3FC0;
        square_start = 1'b1;
        @(negedge clk);                       // after edge k
        square_start = 1'b0;
        repeat (3) @(negedge clk);            // after edge k+3
        num_i        = 16'h4040;
        square_start = 1'b1;
        @(negedge clk);
        square_start = 1'b0;
        repeat (4) @(negedge clk);            // after edge k+8
        chk("ign_valid_pre", {15'd0, valid_o}, 16'd0);
        @(negedge clk);                       // after edge k+9
        chk("ign_valid", {15'd0, valid_o}, 16'd1);
        chk("ign_num", num_o, 16'h4010);
        nvalid = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (valid_o) nvalid++;
        end
        chk("ign_no_second", nvalid[15:0], 16'd0);

        // Reset while the counter is at 4 aborts the operation
        @(negedge clk);
        num_i        = 16'h3FC0;
        square_start = 1'b1;
        @(negedge clk);                       // after edge k
        square_start = 1'b0;
        repeat (4) @(negedge clk);            // after edge k+4, counter = 4
        chk("abort_busy_before", {15'd0, busy_o}, 16'd1);
        rst = 1'b1;
        #1;
        chk("abort_busy", {15'd0, busy_o}, 16'd0);
        chk("abort_valid", {15'd0, valid_o}, 16'd0);
        chk("abort_num", num_o, 16'h0000);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        nvalid = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (valid_o) nvalid++;
        end
        chk("abort_no_valid", nvalid[15:0], 16'd0);
        chk("abort_idle", {15'd0, busy_o}, 16'd0);

        // Unit still works after the abort
        do_op("post_abort", 16'hC040, 16'h4110, 1'b0, 9);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Watchdog so the run always terminates
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
